// File: rtl/fifo_arb_defs.sv
// Shared definitions for the FIFO push arbiter: state encoding and width helpers.
package fifo_arb_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a burst counter that must hold the value max_burst itself.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_priority_pick.sv
// Round-robin picker: first requester with req set, searching upward from last+1.
import fifo_arb_defs::*;

module rr_priority_pick #(
  parameter int requesters = 4,
  localparam int IW = idx_width(requesters)
) (
  input  logic [requesters-1:0] req,
  input  logic [IW-1:0]         last,
  output logic                  found,
  output logic [IW-1:0]         winner
);

  logic [IW-1:0] w_idx;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_idx  = '0;
    // Offset 1 is the highest priority, offset requesters (last itself) the lowest.
    for (int k = 1; k <= requesters; k++) begin
      w_idx = IW'((int'(last) + k) % requesters);
      if (!found && req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO push port among several producers,
// with bounded bursts per owner and zero-latency combinational grant.
import fifo_arb_defs::*;

module fifo_push_arbiter #(
  parameter int bits       = 8,
  parameter int requesters = 4,
  parameter int max_burst  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [requesters-1:0]      req,
  input  logic [requesters*bits-1:0] din,
  input  logic                       full,
  output logic [requesters-1:0]      gnt,
  output logic                       push,
  output logic [bits-1:0]            dout,
  output logic                       busy
);

  localparam int IW = idx_width(requesters);
  localparam int CW = cnt_width(max_burst);
  localparam logic [CW-1:0] CNT_MAX = CW'(max_burst);

  arb_state_t    r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_cnt;

  arb_state_t          w_state_nxt;
  logic [IW-1:0]       w_owner_nxt;
  logic [IW-1:0]       w_last_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CW-1:0]       w_cnt_inc;
  logic [requesters-1:0] w_gnt;
  logic [IW-1:0]       w_sel;
  logic                w_found;
  logic [IW-1:0]       w_pick;
  logic [bits-1:0]     w_words [requesters];

  rr_priority_pick #(
    .requesters(requesters)
  ) u_pick (
    .req   (req),
    .last  (r_last),
    .found (w_found),
    .winner(w_pick)
  );

  for (genvar i = 0; i < requesters; i++) begin : g_words
    assign w_words[i] = din[i*bits +: bits];
  end

  assign w_cnt_inc = r_cnt + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt       = '0;
    w_sel       = r_owner;
    if (rst) begin
      // Outputs stay quiet during reset regardless of req; registers are cleared asynchronously.
    end else if (r_state == ST_BURST && req[r_owner]) begin
      if (!full) begin
        w_gnt[r_owner] = 1'b1;
        w_cnt_nxt      = w_cnt_inc;
        if (w_cnt_inc == CNT_MAX) w_state_nxt = ST_IDLE;
      end
    end else begin
      // Idle, or the owner dropped req: arbitrate this same cycle so there is no bubble.
      w_state_nxt = ST_IDLE;
      if (!full && w_found) begin
        w_gnt[w_pick] = 1'b1;
        w_sel         = w_pick;
        w_last_nxt    = w_pick;
        w_owner_nxt   = w_pick;
        w_cnt_nxt     = CW'(1);
        w_state_nxt   = (max_burst > 1) ? ST_BURST : ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_last  <= IW'(requesters - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign gnt  = w_gnt;
  assign push = |w_gnt;
  assign dout = push ? w_words[w_sel] : '0;
  assign busy = (r_state == ST_BURST) && !rst;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: one instance with max_burst=1, one with max_burst=4,
// directed vectors feeding a scoreboard queue drained by a negedge monitor.
module tb_fifo_push_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req1, req4;
  logic        full1, full4;
  logic [31:0] din;
  logic [3:0]  gnt1, gnt4;
  logic        push1, push4, busy1, busy4;
  logic [7:0]  dout1, dout4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tag    = 0;

  typedef struct {
    int         dut;
    int         tag;
    logic [3:0] gnt;
    logic       push;
    logic [7:0] dout;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fifo_push_arbiter #(.bits(8), .requesters(4), .max_burst(1)) u_rr (
    .clk(clk), .rst(rst), .req(req1), .din(din), .full(full1),
    .gnt(gnt1), .push(push1), .dout(dout1), .busy(busy1)
  );

  fifo_push_arbiter #(.bits(8), .requesters(4), .max_burst(4)) u_bu (
    .clk(clk), .rst(rst), .req(req4), .din(din), .full(full4),
    .gnt(gnt4), .push(push4), .dout(dout4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input int dut, input logic [3:0] g, input logic p,
                            input logic [7:0] d, input logic b);
    exp_t e;
    e.dut = dut; e.tag = n_tag; e.gnt = g; e.push = p; e.dout = d; e.busy = b;
    sb_q.push_back(e);
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n_tag++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req1 = '0; req4 = '0; full1 = 1'b0; full4 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.dut == 1) begin
        check($sformatf("mb1 c%0d gnt", e.tag),  32'(gnt1),  32'(e.gnt));
        check($sformatf("mb1 c%0d push", e.tag), 32'(push1), 32'(e.push));
        check($sformatf("mb1 c%0d dout", e.tag), 32'(dout1), 32'(e.dout));
        check($sformatf("mb1 c%0d busy", e.tag), 32'(busy1), 32'(e.busy));
      end else begin
        check($sformatf("mb4 c%0d gnt", e.tag),  32'(gnt4),  32'(e.gnt));
        check($sformatf("mb4 c%0d push", e.tag), 32'(push4), 32'(e.push));
        check($sformatf("mb4 c%0d dout", e.tag), 32'(dout4), 32'(e.dout));
        check($sformatf("mb4 c%0d busy", e.tag), 32'(busy4), 32'(e.busy));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    din   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst   = 1'b1;
    req1  = 4'b1111; req4 = 4'b1111;
    full1 = 1'b0;    full4 = 1'b0;
    #1;
    // Reset holds every output low even with all requests pending.
    check("rst gnt1",  32'(gnt1),  32'h0);
    check("rst push1", 32'(push1), 32'h0);
    check("rst busy1", 32'(busy1), 32'h0);
    check("rst gnt4",  32'(gnt4),  32'h0);
    check("rst push4", 32'(push4), 32'h0);
    check("rst dout4", 32'(dout4), 32'h0);
    check("rst busy4", 32'(busy4), 32'h0);
    tick();
    rst = 1'b0;

    // Pure round-robin on the max_burst=1 instance; first-cycle priority on both.
    expect_out(1, 4'b0001, 1'b1, 8'hA0, 1'b0);
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b0);
    tick();
    req4 = 4'b0000;
    expect_out(1, 4'b0010, 1'b1, 8'hA1, 1'b0); tick();
    expect_out(1, 4'b0100, 1'b1, 8'hA2, 1'b0); tick();
    expect_out(1, 4'b1000, 1'b1, 8'hA3, 1'b0); tick();
    expect_out(1, 4'b0001, 1'b1, 8'hA0, 1'b0); tick();
    full1 = 1'b1;
    expect_out(1, 4'b0000, 1'b0, 8'h00, 1'b0); tick();
    full1 = 1'b0;
    expect_out(1, 4'b0010, 1'b1, 8'hA1, 1'b0); tick();

    // Single requester on max_burst=4: continuous grant, busy 0,1,1,1,0,1.
    do_reset();
    req4 = 4'b0100;
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b0); tick();
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b1); tick();
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b1); tick();
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b1); tick();
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b0); tick();
    expect_out(4, 4'b0100, 1'b1, 8'hA2, 1'b1); tick();

    // Full stalls the burst for two cycles without losing ownership, then rotation.
    do_reset();
    req4 = 4'b0011;
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b0); tick();
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b1); tick();
    full4 = 1'b1;
    expect_out(4, 4'b0000, 1'b0, 8'h00, 1'b1); tick();
    expect_out(4, 4'b0000, 1'b0, 8'h00, 1'b1); tick();
    full4 = 1'b0;
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b1); tick();
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b1); tick();
    expect_out(4, 4'b0010, 1'b1, 8'hA1, 1'b0); tick();

    // Owner drop mid-burst hands over to requester 3 in the same cycle.
    do_reset();
    req4 = 4'b1001;
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b0); tick();
    req4 = 4'b1000;
    expect_out(4, 4'b1000, 1'b1, 8'hA3, 1'b1); tick();
    expect_out(4, 4'b1000, 1'b1, 8'hA3, 1'b1); tick();

    // Reset between edges mid-burst clears outputs at once; reset priority afterwards.
    do_reset();
    req4 = 4'b0001;
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b0); tick();
    expect_out(4, 4'b0001, 1'b1, 8'hA0, 1'b1); tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst gnt4",  32'(gnt4),  32'h0);
    check("midrst push4", 32'(push4), 32'h0);
    check("midrst dout4", 32'(dout4), 32'h0);
    check("midrst busy4", 32'(busy4), 32'h0);
    tick();
    rst  = 1'b0;
    req4 = 4'b0110;
    expect_out(4, 4'b0010, 1'b1, 8'hA1, 1'b0); tick();
    expect_out(4, 4'b0010, 1'b1, 8'hA1, 1'b1); tick();

    tick();
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
